// File: rtl/idex_pipe_reg.sv
// rtl/idex_pipe_reg.sv - ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional perf counters (BubbleCnt, FlushCnt) are built when IDEX_PERF_CNT_EN is defined.
module idex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_SignExt,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_RegWrite,
  input  logic              ID_MemToReg,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic              ID_Branch,
  input  logic [1:0]        ID_ALUOp,
  input  logic              Flush,
  input  logic              Hold,
  output logic [DATA_W-1:0] IDEX_PC4,
  output logic [DATA_W-1:0] IDEX_ReadData1,
  output logic [DATA_W-1:0] IDEX_ReadData2,
  output logic [DATA_W-1:0] IDEX_SignExt,
  output logic [REG_W-1:0]  IDEX_Rs,
  output logic [REG_W-1:0]  IDEX_Rt,
  output logic [REG_W-1:0]  IDEX_Rd,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemToReg,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic              IDEX_ALUSrc,
  output logic              IDEX_RegDst,
  output logic              IDEX_Branch,
  output logic [1:0]        IDEX_ALUOp,
  output logic              IDEX_Valid,
  output logic              Stall
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]       BubbleCnt,
  output logic [31:0]       FlushCnt
`endif
);

  logic lu;

  // A load already in EX whose destination is read by the instruction in ID.
  assign lu = IDEX_MemRead & IDEX_Valid & (IDEX_Rt != '0) &
              ((IDEX_Rt == ID_Rs) | (IDEX_Rt == ID_Rt));

  // Hold freezes PC/IF-ID on its own path; a flush discards the ID instruction anyway.
  assign Stall = lu & ~Flush & ~Hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      IDEX_PC4       <= '0;
      IDEX_ReadData1 <= '0;
      IDEX_ReadData2 <= '0;
      IDEX_SignExt   <= '0;
      IDEX_Rs        <= '0;
      IDEX_Rt        <= '0;
      IDEX_Rd        <= '0;
      IDEX_RegWrite  <= 1'b0;
      IDEX_MemToReg  <= 1'b0;
      IDEX_MemRead   <= 1'b0;
      IDEX_MemWrite  <= 1'b0;
      IDEX_ALUSrc    <= 1'b0;
      IDEX_RegDst    <= 1'b0;
      IDEX_Branch    <= 1'b0;
      IDEX_ALUOp     <= 2'b00;
      IDEX_Valid     <= 1'b0;
    end else if (Flush) begin
      IDEX_PC4       <= ID_PC4;
      IDEX_ReadData1 <= ID_ReadData1;
      IDEX_ReadData2 <= ID_ReadData2;
      IDEX_SignExt   <= ID_SignExt;
      IDEX_Rs        <= ID_Rs;
      IDEX_Rt        <= ID_Rt;
      IDEX_Rd        <= ID_Rd;
      IDEX_RegWrite  <= 1'b0;
      IDEX_MemToReg  <= 1'b0;
      IDEX_MemRead   <= 1'b0;
      IDEX_MemWrite  <= 1'b0;
      IDEX_ALUSrc    <= 1'b0;
      IDEX_RegDst    <= 1'b0;
      IDEX_Branch    <= 1'b0;
      IDEX_ALUOp     <= 2'b00;
      IDEX_Valid     <= 1'b0;
    end else if (Hold) begin
      IDEX_Valid     <= IDEX_Valid;
    end else if (lu) begin
      // Zeroed specifiers keep the forwarding unit from matching on the bubble.
      IDEX_Rs        <= '0;
      IDEX_Rt        <= '0;
      IDEX_Rd        <= '0;
      IDEX_RegWrite  <= 1'b0;
      IDEX_MemToReg  <= 1'b0;
      IDEX_MemRead   <= 1'b0;
      IDEX_MemWrite  <= 1'b0;
      IDEX_ALUSrc    <= 1'b0;
      IDEX_RegDst    <= 1'b0;
      IDEX_Branch    <= 1'b0;
      IDEX_ALUOp     <= 2'b00;
      IDEX_Valid     <= 1'b0;
    end else begin
      IDEX_PC4       <= ID_PC4;
      IDEX_ReadData1 <= ID_ReadData1;
      IDEX_ReadData2 <= ID_ReadData2;
      IDEX_SignExt   <= ID_SignExt;
      IDEX_Rs        <= ID_Rs;
      IDEX_Rt        <= ID_Rt;
      IDEX_Rd        <= ID_Rd;
      IDEX_RegWrite  <= ID_RegWrite;
      IDEX_MemToReg  <= ID_MemToReg;
      IDEX_MemRead   <= ID_MemRead;
      IDEX_MemWrite  <= ID_MemWrite;
      IDEX_ALUSrc    <= ID_ALUSrc;
      IDEX_RegDst    <= ID_RegDst;
      IDEX_Branch    <= ID_Branch;
      IDEX_ALUOp     <= ID_ALUOp;
      IDEX_Valid     <= 1'b1;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      BubbleCnt <= '0;
      FlushCnt  <= '0;
    end else begin
      if (Flush)
        FlushCnt <= FlushCnt + 32'd1;
      if (!Flush && !Hold && lu)
        BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb/tb_idex_pipe_reg.sv - table-driven bench for idex_pipe_reg.
// Counter checks are compiled when IDEX_PERF_CNT_EN is defined.
module tb_idex_pipe_reg;

  logic        clk;
  logic        rst;
  logic [31:0] ID_PC4, ID_ReadData1, ID_ReadData2, ID_SignExt;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic        ID_RegWrite, ID_MemToReg, ID_MemRead, ID_MemWrite;
  logic        ID_ALUSrc, ID_RegDst, ID_Branch;
  logic [1:0]  ID_ALUOp;
  logic        Flush, Hold;
  logic [31:0] IDEX_PC4, IDEX_ReadData1, IDEX_ReadData2, IDEX_SignExt;
  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic        IDEX_RegWrite, IDEX_MemToReg, IDEX_MemRead, IDEX_MemWrite;
  logic        IDEX_ALUSrc, IDEX_RegDst, IDEX_Branch;
  logic [1:0]  IDEX_ALUOp;
  logic        IDEX_Valid, Stall;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] BubbleCnt, FlushCnt;
`endif

  logic [8:0]  ctrl_in;
  logic [31:0] pc_in;
  logic [8:0]  ctrl_out;

  // ctrl bit order: RegWrite MemToReg MemRead MemWrite ALUSrc RegDst Branch ALUOp[1:0]
  assign {ID_RegWrite, ID_MemToReg, ID_MemRead, ID_MemWrite, ID_ALUSrc,
          ID_RegDst, ID_Branch, ID_ALUOp} = ctrl_in;
  assign ctrl_out = {IDEX_RegWrite, IDEX_MemToReg, IDEX_MemRead, IDEX_MemWrite,
                     IDEX_ALUSrc, IDEX_RegDst, IDEX_Branch, IDEX_ALUOp};
  assign ID_PC4       = pc_in;
  assign ID_ReadData1 = pc_in << 8;
  assign ID_ReadData2 = pc_in << 16;
  assign ID_SignExt   = pc_in << 4;

  idex_pipe_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .ID_PC4(ID_PC4), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_SignExt(ID_SignExt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_RegWrite(ID_RegWrite), .ID_MemToReg(ID_MemToReg), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
    .ID_Branch(ID_Branch), .ID_ALUOp(ID_ALUOp), .Flush(Flush), .Hold(Hold),
    .IDEX_PC4(IDEX_PC4), .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2),
    .IDEX_SignExt(IDEX_SignExt), .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemToReg(IDEX_MemToReg),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
    .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_RegDst(IDEX_RegDst), .IDEX_Branch(IDEX_Branch),
    .IDEX_ALUOp(IDEX_ALUOp), .IDEX_Valid(IDEX_Valid), .Stall(Stall)
`ifdef IDEX_PERF_CNT_EN
    , .BubbleCnt(BubbleCnt), .FlushCnt(FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, flush, hold;
    logic [8:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic [31:0] pc;
    logic       chk_stall, e_stall;
    logic       e_valid;
    logic [8:0] e_ctrl;
    logic       chk_spec;
    logic [4:0] e_rs, e_rt, e_rd;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string name, logic r, logic f, logic h, logic [8:0] c,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [31:0] pc,
                              logic cs, logic es, logic ev, logic [8:0] ec, logic csp,
                              logic [4:0] ers, logic [4:0] ert, logic [4:0] erd, logic [31:0] epc);
    vec_t v;
    v.name = name; v.rst = r; v.flush = f; v.hold = h; v.ctrl = c;
    v.rs = rs; v.rt = rt; v.rd = rd; v.pc = pc;
    v.chk_stall = cs; v.e_stall = es; v.e_valid = ev; v.e_ctrl = ec;
    v.chk_spec = csp; v.e_rs = ers; v.e_rt = ert; v.e_rd = erd; v.e_pc = epc;
    return v;
  endfunction

  initial begin
    int stalls;
    bit captured;
    rst = 1'b1; Flush = 1'b0; Hold = 1'b0;
    ctrl_in = '0; pc_in = '0; ID_Rs = '0; ID_Rt = '0; ID_Rd = '0;

    // lw = 0x1D0, add = 0x10A
    //              name        rst f h ctrl    rs rt rd pc   cs es  v ectrl  csp ers ert erd epc
    vecs.push_back(mk("rst0",      1,0,0,9'h1FF, 3, 4, 5,100, 0,0, 0,9'h000,1, 0, 0, 0,  0));
    vecs.push_back(mk("rst1",      1,0,0,9'h1FF, 3, 4, 5,100, 1,0, 0,9'h000,1, 0, 0, 0,  0));
    vecs.push_back(mk("first",     0,0,0,9'h100, 3, 0, 0,  4, 1,0, 1,9'h100,1, 3, 0, 0,  4));
    vecs.push_back(mk("lw9",       0,0,0,9'h1D0, 8, 9, 0,  8, 1,0, 1,9'h1D0,1, 8, 9, 0,  8));
    vecs.push_back(mk("lu_bub",    0,0,0,9'h10A, 9,10,11, 12, 1,1, 0,9'h000,1, 0, 0, 0,  8));
    vecs.push_back(mk("lu_rep",    0,0,0,9'h10A, 9,10,11, 12, 1,0, 1,9'h10A,1, 9,10,11, 12));
    vecs.push_back(mk("lw_r0",     0,0,0,9'h1D0, 1, 0, 0, 16, 1,0, 1,9'h1D0,1, 1, 0, 0, 16));
    vecs.push_back(mk("r0dep",     0,0,0,9'h10A, 0, 0, 2, 20, 1,0, 1,9'h10A,1, 0, 0, 2, 20));
    vecs.push_back(mk("lw9b",      0,0,0,9'h1D0, 2, 9, 0, 24, 1,0, 1,9'h1D0,1, 2, 9, 0, 24));
    vecs.push_back(mk("indep",     0,0,0,9'h10A, 4, 5, 6, 28, 1,0, 1,9'h10A,1, 4, 5, 6, 28));
    vecs.push_back(mk("lw9c",      0,0,0,9'h1D0, 1, 9, 0, 32, 1,0, 1,9'h1D0,1, 1, 9, 0, 32));
    vecs.push_back(mk("flush_pri", 0,1,1,9'h10A, 9, 9, 3, 36, 1,0, 0,9'h000,0, 0, 0, 0,  0));
    vecs.push_back(mk("lw7",       0,0,0,9'h1D0, 1, 7, 0, 40, 1,0, 1,9'h1D0,1, 1, 7, 0, 40));
    vecs.push_back(mk("hold1",     0,0,1,9'h10A, 7, 7, 1, 44, 1,0, 1,9'h1D0,1, 1, 7, 0, 40));
    vecs.push_back(mk("hold2",     0,0,1,9'h1FF, 3, 3, 0, 48, 1,0, 1,9'h1D0,1, 1, 7, 0, 40));
    vecs.push_back(mk("hold3",     0,0,1,9'h10A, 7, 2, 2, 52, 1,0, 1,9'h1D0,1, 1, 7, 0, 40));
    vecs.push_back(mk("hold_rel",  0,0,0,9'h10A, 4, 2, 3, 56, 1,0, 1,9'h10A,1, 4, 2, 3, 56));
    vecs.push_back(mk("lw6",       0,0,0,9'h1D0, 1, 6, 0, 60, 1,0, 1,9'h1D0,1, 1, 6, 0, 60));
    vecs.push_back(mk("rst_mid",   1,0,0,9'h10A, 6, 2, 3, 64, 1,1, 0,9'h000,1, 0, 0, 0,  0));
    vecs.push_back(mk("post_rst",  0,0,0,9'h10A, 6, 2, 3, 64, 1,0, 1,9'h10A,1, 6, 2, 3, 64));
    vecs.push_back(mk("lw5",       0,0,0,9'h1D0, 1, 5, 0, 72, 1,0, 1,9'h1D0,1, 1, 5, 0, 72));
    vecs.push_back(mk("lwlw_bub",  0,0,0,9'h1D0, 5, 6, 0, 76, 1,1, 0,9'h000,1, 0, 0, 0, 72));
    vecs.push_back(mk("lwlw_rep",  0,0,0,9'h1D0, 5, 6, 0, 76, 1,0, 1,9'h1D0,1, 5, 6, 0, 76));
    vecs.push_back(mk("use_bub",   0,0,0,9'h10A, 6, 8, 7, 80, 1,1, 0,9'h000,1, 0, 0, 0, 76));
    vecs.push_back(mk("use_rep",   0,0,0,9'h10A, 6, 8, 7, 80, 1,0, 1,9'h10A,1, 6, 8, 7, 80));
    vecs.push_back(mk("flush2",    0,1,0,9'h1FF, 1, 2, 3, 84, 1,0, 0,9'h000,0, 0, 0, 0,  0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; Flush = vecs[i].flush; Hold = vecs[i].hold;
      ctrl_in = vecs[i].ctrl; pc_in = vecs[i].pc;
      ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt; ID_Rd = vecs[i].rd;
      #1;
      if (vecs[i].chk_stall) check({vecs[i].name, ".stall"}, 32'(Stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check({vecs[i].name, ".valid"}, 32'(IDEX_Valid), 32'(vecs[i].e_valid));
      check({vecs[i].name, ".ctrl"}, 32'(ctrl_out), 32'(vecs[i].e_ctrl));
      if (vecs[i].chk_spec) begin
        check({vecs[i].name, ".rs"}, 32'(IDEX_Rs), 32'(vecs[i].e_rs));
        check({vecs[i].name, ".rt"}, 32'(IDEX_Rt), 32'(vecs[i].e_rt));
        check({vecs[i].name, ".rd"}, 32'(IDEX_Rd), 32'(vecs[i].e_rd));
        check({vecs[i].name, ".pc4"}, IDEX_PC4, vecs[i].e_pc);
        check({vecs[i].name, ".rd1"}, IDEX_ReadData1, vecs[i].e_pc << 8);
        check({vecs[i].name, ".rd2"}, IDEX_ReadData2, vecs[i].e_pc << 16);
        check({vecs[i].name, ".sext"}, IDEX_SignExt, vecs[i].e_pc << 4);
      end
    end

`ifdef IDEX_PERF_CNT_EN
    // Since rst_mid: bubbles at lwlw_bub and use_bub, one flush at flush2.
    check("bubble_cnt", BubbleCnt, 32'd2);
    check("flush_cnt", FlushCnt, 32'd1);
`endif

    // Dependent consumer held in ID must stall exactly once, then be captured.
    @(negedge clk);
    Flush = 1'b0; Hold = 1'b0; rst = 1'b0;
    ctrl_in = 9'h1D0; pc_in = 88; ID_Rs = 1; ID_Rt = 3; ID_Rd = 0;
    @(negedge clk);
    ctrl_in = 9'h10A; pc_in = 92; ID_Rs = 3; ID_Rt = 0; ID_Rd = 4;
    stalls = 0;
    captured = 1'b0;
    for (int k = 0; k < 4 && !captured; k++) begin
      #1;
      if (Stall) stalls++;
      @(posedge clk);
      #1;
      if (IDEX_Valid && IDEX_Rs == 5'd3 && ctrl_out == 9'h10A) captured = 1'b1;
      @(negedge clk);
    end
    check("seq_stall_cycles", 32'(stalls), 32'd1);
    check("seq_captured", 32'(captured), 32'd1);
    check("seq_pc4", IDEX_PC4, 32'd92);

`ifdef IDEX_PERF_CNT_EN
    check("bubble_cnt2", BubbleCnt, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
